keypad_scanner: RTL and testbench

Matrix-keypad front end that produces the write side of the 8-digit display register file. Drives a 4x4 keypad column by column, synchronises and debounces the row returns, and resolves a single pressed key to a 4-bit hex code. Each accepted press is emitted as a one-cycle write (`wr_en`/`wr_addr`/`wr_data`) to the next display digit, with an auto-incrementing digit pointer.

---
 rtl/keypad_scanner_pkg.sv | 44 ++++
 rtl/keypad_scanner_if.sv | 36 +++
 rtl/keypad_scanner_tick_gen.sv | 36 +++
 rtl/keypad_scanner.sv | 269 ++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_pkg                                                                 |
// | Shared types and helpers for the 4x4 matrix keypad scanner: FSM state      |
// | encoding, per-scan result classification, idle-row constants, the          |
// | active-low column lookup and the row*4+col key code function.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package keypad_pkg;

  // Debounce state machine
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_e;

  // Classification of one complete four-column scan
  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  // Rows read back when no key pulls a line low (pulled-up, active-low)
  localparam logic [3:0] KEY_NONE_ROWS = 4'b1111;
  // Code held in the scan accumulator while no key has been found yet
  localparam logic [3:0] KEY_NONE_CODE = 4'h0;

  // Active-low one-hot column drive for column index col
  function automatic logic [3:0] col_onehot_n(input logic [1:0] col);
    logic [3:0] onehot;
    onehot = 4'b0001 << col;
    return ~onehot;
  endfunction

  // Key code is row*4 + col, i.e. simple bit concatenation
  function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scanner_if                                                          |
// | Keypad matrix pins plus the display register-file write port.             |
// |   row_in   : keypad rows, active-low, asynchronous                          |
// |   col_out  : column drive, active-low one-hot                               |
// |   key_code : last accepted key (row*4+col)                                  |
// |   key_valid: one-cycle pulse on press acceptance                            |
// |   key_held : high from acceptance until release acceptance                  |
// |   wr_en    : one-cycle display write strobe (coincident with key_valid)     |
// |   wr_addr  : digit written by the current wr_en                             |
// |   wr_data  : key code written by the current wr_en                          |
// | master = scanner side, slave = keypad / display side.                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_held, wr_en, wr_addr, wr_data
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_held, wr_en, wr_addr, wr_data
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kp_tick_gen                                                                |
// | Free-running modulo-DIV counter; o_tick is high for the single cycle in    |
// | which the count equals DIV-1.                                              |
// |   clk    : system clock                                                    |
// |   rst_n  : asynchronous active-low reset (count returns to 0)              |
// |   o_tick : one-cycle pulse every DIV cycles                                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module kp_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);
  localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + C_ONE;
    end
  end
endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scanner                                                             |
// | 4x4 matrix keypad front end. Drives columns one at a time, synchronises   |
// | the row returns, classifies every full scan as NONE / SINGLE / MULTI,     |
// | debounces press and release over DEBOUNCE_SCANS scans and emits each      |
// | accepted press as a one-cycle write to the next display digit.            |
// |   clk  : system clock, rising edge                                         |
// |   rst2 : asynchronous active-low reset                                     |
// |   kp   : keypad pins and display write port (keypad_scanner_if.master)    |
// | Parameters: CLK_HZ, SCAN_HZ (CLK_HZ/SCAN_HZ integer >= 4),                |
// |             DEBOUNCE_SCANS (>= 2)                                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 20
) (
  input  logic             clk,
  input  logic             rst2,
  keypad_scanner_if.master kp
);
  localparam int               DIV       = CLK_HZ / SCAN_HZ;
  localparam int               CNT_W     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Row synchroniser (idle level is all-ones so reset looks like "no key")
  // --------------------------------------------------------------------------
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      r_sync1 <= KEY_NONE_ROWS;
      r_sync2 <= KEY_NONE_ROWS;
    end else begin
      r_sync1 <= kp.row_in;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Column stepping
  // --------------------------------------------------------------------------
  logic       w_tick;
  logic [1:0] r_col;
  logic       w_eos;

  kp_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst2),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      r_col <= 2'd0;
    end else if (w_tick) begin
      r_col <= r_col + 2'd1;
    end
  end

  // Column is a register, so col_out changes the cycle after tick and the
  // rows for that column have DIV cycles to pass through the synchroniser.
  assign kp.col_out = col_onehot_n(r_col);

  // The tick that samples column 3 completes a scan
  assign w_eos = w_tick && (r_col == 2'd3);

  // --------------------------------------------------------------------------
  // Per-column decode and scan accumulation
  // --------------------------------------------------------------------------
  logic [3:0] w_low;
  logic [2:0] w_col_lows;
  logic [1:0] w_col_row;

  assign w_low = ~r_sync2;

  always_comb begin
    w_col_lows = 3'd0;
    w_col_row  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_low[i]) begin
        w_col_lows = w_col_lows + 3'd1;
        w_col_row  = 2'(i);
      end
    end
  end

  // r_acc_lows saturates at 2: only "none / one / more than one" matters
  logic [1:0] r_acc_lows;
  logic [3:0] r_acc_code;
  logic [2:0] w_sum;
  logic [1:0] w_scan_lows;
  logic [3:0] w_scan_code;
  scan_kind_e w_kind;

  always_comb begin
    w_sum       = {1'b0, r_acc_lows} + w_col_lows;
    w_scan_lows = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_scan_code = r_acc_code;
    // The code is only meaningful when this sample supplies the very first low
    if ((r_acc_lows == 2'd0) && (w_col_lows == 3'd1)) begin
      w_scan_code = key_code_of(w_col_row, r_col);
    end
    case (w_scan_lows)
      2'd0:    w_kind = SCAN_NONE;
      2'd1:    w_kind = SCAN_SINGLE;
      default: w_kind = SCAN_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      r_acc_lows <= 2'd0;
      r_acc_code <= KEY_NONE_CODE;
    end else if (w_tick) begin
      if (w_eos) begin
        r_acc_lows <= 2'd0;
        r_acc_code <= KEY_NONE_CODE;
      end else begin
        r_acc_lows <= w_scan_lows;
        r_acc_code <= w_scan_code;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM (transitions only at end of scan)
  // --------------------------------------------------------------------------
  kp_state_e        r_state;
  kp_state_e        w_state_nxt;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_accept;
  logic             w_release;

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      r_state <= ST_IDLE;
      r_cand  <= KEY_NONE_CODE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    w_cnt_inc   = r_cnt + C_CNT_ONE;

    if (w_eos) begin
      case (r_state)
        ST_IDLE: begin
          if (w_kind == SCAN_SINGLE) begin
            w_state_nxt = ST_PRESS_DB;
            w_cand_nxt  = w_scan_code;
            w_cnt_nxt   = C_CNT_ONE;
          end
        end

        ST_PRESS_DB: begin
          if ((w_kind == SCAN_SINGLE) && (w_scan_code == r_cand)) begin
            if (w_cnt_inc == C_DB_LAST) begin
              w_state_nxt = ST_HELD;
              w_cnt_nxt   = '0;
              w_accept    = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else if (w_kind == SCAN_SINGLE) begin
            // A different single key restarts debouncing on that key
            w_cand_nxt = w_scan_code;
            w_cnt_nxt  = C_CNT_ONE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end

        ST_HELD: begin
          // Extra keys while held are ignored: no rollover
          if (w_kind == SCAN_NONE) begin
            w_state_nxt = ST_RELEASE_DB;
            w_cnt_nxt   = C_CNT_ONE;
          end
        end

        ST_RELEASE_DB: begin
          if (w_kind == SCAN_NONE) begin
            if (w_cnt_inc == C_DB_LAST) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
              w_release   = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = '0;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Event outputs and digit pointer
  // --------------------------------------------------------------------------
  logic [3:0] r_key_code;
  logic       r_key_valid;
  logic       r_key_held;
  logic [2:0] r_ptr;

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      r_key_code  <= KEY_NONE_CODE;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_ptr       <= 3'd0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= r_cand;
      end
      if (w_accept) begin
        r_key_held <= 1'b1;
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
      // Pointer moves the cycle after the write so wr_addr names the digit
      // being written during wr_en; 3-bit wrap gives 7 -> 0.
      if (r_key_valid) begin
        r_ptr <= r_ptr + 3'd1;
      end
    end
  end

  // key_code and wr_data are the same held value, so one register feeds both
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;
  assign kp.wr_en     = r_key_valid;
  assign kp.wr_addr   = r_ptr;
  assign kp.wr_data   = r_key_code;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_keypad_scanner                                                          |
// | Self-checking bench for keypad_scanner with DIV=4, DEBOUNCE_SCANS=3.      |
// | A keypad model pulls a row low whenever a pressed key's column is driven. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_keypad_scanner;
  localparam int CLK_HZ   = 16;
  localparam int SCAN_HZ  = 4;
  localparam int DB       = 3;
  localparam int SCAN_CYC = 16;

  logic        clk  = 1'b0;
  logic        rst2 = 1'b0;
  logic [15:0] keys = 16'h0;

  int errors = 0;
  int checks = 0;

  keypad_scanner_if bus ();

  keypad_scanner #(
    .CLK_HZ         (CLK_HZ),
    .SCAN_HZ        (SCAN_HZ),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk  (clk),
    .rst2 (rst2),
    .kp   (bus)
  );

  always #5 clk = ~clk;

  // Keypad matrix model
  always_comb begin
    bus.row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4 + c] && !bus.col_out[c]) bus.row_in[r] = 1'b0;
      end
    end
  end

  typedef struct {
    logic        do_rst;
    logic [15:0] keys;
    int          scans;
    int          exp_ev;
    logic [3:0]  exp_data;
    logic [2:0]  exp_addr;
    logic        exp_held;
  } step_t;

  step_t tbl [0:39];
  int    n_steps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [15:0] k, input int sc, input int ev,
                     input logic [3:0] d, input logic [2:0] a, input logic h);
    tbl[n_steps].do_rst   = r;
    tbl[n_steps].keys     = k;
    tbl[n_steps].scans    = sc;
    tbl[n_steps].exp_ev   = ev;
    tbl[n_steps].exp_data = d;
    tbl[n_steps].exp_addr = a;
    tbl[n_steps].exp_held = h;
    n_steps++;
  endtask

  // Stop at the first negedge of a column-0 phase (start of a scan)
  task automatic align_scan();
    int n;
    n = 0;
    while (bus.col_out == 4'b1110 && n < 64) begin @(negedge clk); n++; end
    while (bus.col_out != 4'b1110 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) chk("align_timeout", {28'h0, bus.col_out}, 32'he);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst2 = 1'b0;
    repeat (3) @(negedge clk);
    rst2 = 1'b1;
    align_scan();
  endtask

  task automatic run_step(input step_t s, input int idx);
    int         ev;
    logic [3:0] last_data;
    logic [2:0] last_addr;
    ev = 0;
    last_data = 4'h0;
    last_addr = 3'd0;
    if (s.do_rst) do_reset();
    keys = s.keys;
    repeat (s.scans * SCAN_CYC) begin
      @(negedge clk);
      if (bus.wr_en || bus.key_valid) begin
        chk($sformatf("step%0d_valid_eq_wren", idx), {31'h0, bus.key_valid}, {31'h0, bus.wr_en});
        if (bus.wr_en) begin
          ev++;
          last_data = bus.wr_data;
          last_addr = bus.wr_addr;
          chk($sformatf("step%0d_keycode", idx), {28'h0, bus.key_code}, {28'h0, bus.wr_data});
          chk($sformatf("step%0d_held_at_valid", idx), {31'h0, bus.key_held}, 32'h1);
        end
      end
    end
    chk($sformatf("step%0d_events", idx), ev, s.exp_ev);
    if (s.exp_ev > 0) begin
      chk($sformatf("step%0d_wr_data", idx), {28'h0, last_data}, {28'h0, s.exp_data});
      chk($sformatf("step%0d_wr_addr", idx), {29'h0, last_addr}, {29'h0, s.exp_addr});
    end
    chk($sformatf("step%0d_held", idx), {31'h0, bus.key_held}, {31'h0, s.exp_held});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] k9, k15, k3, k5;
    k9  = 16'h1 << 9;
    k15 = 16'h1 << 15;
    k3  = 16'h1 << 3;
    k5  = 16'h1 << 5;
    n_steps = 0;

    // ---------------- table ----------------
    add(0, 16'h0, 4, 0, 4'h0, 3'd0, 0);          // idle, nothing happens
    add(0, k9, 10, 1, 4'h9, 3'd0, 1);            // single press
    add(0, 16'h0, 2, 0, 4'h0, 3'd0, 1);          // 2 empty scans: still held
    add(0, 16'h0, 1, 0, 4'h0, 3'd0, 0);          // 3rd empty scan releases
    for (int i = 0; i < 8; i++)                  // 1-on/1-off bounce
      add(0, (i % 2 == 0) ? k9 : 16'h0, 1, 0, 4'h0, 3'd0, 0);
    add(0, 16'h0, 2, 0, 4'h0, 3'd0, 0);
    add(0, k9, 2, 0, 4'h0, 3'd0, 0);             // too short
    add(0, 16'h0, 2, 0, 4'h0, 3'd0, 0);
    for (int i = 0; i < 9; i++) begin            // pointer wrap after reset
      add((i == 0), k15, 3, 1, 4'hF, 3'(i % 8), 1);
      add(0, 16'h0, 3, 0, 4'h0, 3'd0, 0);
    end
    add(0, k3 | k5, 4, 0, 4'h0, 3'd0, 0);        // multi from idle
    add(0, 16'h0, 1, 0, 4'h0, 3'd0, 0);
    add(0, k3, 3, 1, 4'h3, 3'd1, 1);             // pointer continues at 1
    add(0, k3 | k5, 3, 0, 4'h0, 3'd0, 1);        // rollover ignored
    add(0, k5, 3, 0, 4'h0, 3'd0, 1);             // key 3 released, 5 held
    add(0, 16'h0, 2, 0, 4'h0, 3'd0, 1);
    add(0, 16'h0, 1, 0, 4'h0, 3'd0, 0);

    // ---------------- reset values and column sequence ----------------
    rst2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col_out",   {28'h0, bus.col_out},  32'he);
    chk("rst_key_code",  {28'h0, bus.key_code}, 32'h0);
    chk("rst_key_valid", {31'h0, bus.key_valid}, 32'h0);
    chk("rst_key_held",  {31'h0, bus.key_held}, 32'h0);
    chk("rst_wr_en",     {31'h0, bus.wr_en},    32'h0);
    chk("rst_wr_addr",   {29'h0, bus.wr_addr},  32'h0);
    chk("rst_wr_data",   {28'h0, bus.wr_data},  32'h0);
    rst2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      logic [3:0] oh;
      @(negedge clk);
      oh = 4'b0001 << ((k / 4) % 4);
      chk($sformatf("col_seq_%0d", k), {28'h0, bus.col_out}, {28'h0, ~oh});
      chk($sformatf("idle_outs_%0d", k),
          {24'h0, bus.key_valid, bus.key_held, bus.wr_en, bus.wr_addr, 2'b0},
          32'h0);
    end
    align_scan();

    for (int i = 0; i < n_steps; i++) run_step(tbl[i], i);

    // ---------------- reset during PRESS_DB with cnt=2 ----------------
    keys = k9;
    repeat (2 * SCAN_CYC) @(negedge clk);
    repeat (6) @(negedge clk);
    #1 rst2 = 1'b0;
    #1;
    chk("async_rst_col_out", {28'h0, bus.col_out}, 32'he);
    chk("async_rst_wr_addr", {29'h0, bus.wr_addr}, 32'h0);
    chk("async_rst_key_code", {28'h0, bus.key_code}, 32'h0);
    chk("async_rst_valid", {31'h0, bus.key_valid}, 32'h0);
    repeat (5) @(negedge clk);
    rst2 = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      if (k == 48) begin
        chk("post_rst_valid", {31'h0, bus.key_valid}, 32'h1);
        chk("post_rst_wr_en", {31'h0, bus.wr_en}, 32'h1);
        chk("post_rst_wr_addr", {29'h0, bus.wr_addr}, 32'h0);
        chk("post_rst_wr_data", {28'h0, bus.wr_data}, 32'h9);
        chk("post_rst_key_code", {28'h0, bus.key_code}, 32'h9);
        chk("post_rst_held", {31'h0, bus.key_held}, 32'h1);
      end else begin
        chk($sformatf("post_rst_novalid_%0d", k), {31'h0, bus.key_valid}, 32'h0);
      end
    end
    keys = 16'h0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
